// File: rtl/antares_dmem_controller.sv
// MEM-stage data-memory sequencer: issues request/ready bus transactions, stalls the
// pipeline while an access is outstanding, formats load data and flags misalignment/timeouts.
module antares_dmem_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_mem_read,
    input  logic        mem_mem_write,
    input  logic        mem_mem_byte,
    input  logic        mem_mem_halfword,
    input  logic        mem_mem_sign_ext,
    input  logic [31:0] mem_alu_data,
    input  logic [31:0] mem_store_data,
    input  logic        mem_flush,
    input  logic        ext_stall,
    input  logic [31:0] dmem_data_i,
    input  logic        dmem_ready,
    output logic        dmem_request,
    output logic        dmem_we,
    output logic [31:0] dmem_address,
    output logic [3:0]  dmem_sel,
    output logic [31:0] dmem_data_o,
    output logic [31:0] mem_read_data,
    output logic        mem_stall_req,
    output logic        exc_addr_load,
    output logic        exc_addr_store,
    output logic        exc_bus_error
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        berr_q, berr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        abort_q, abort_d;
    logic [1:0]  lo_q, lo_d;
    logic        byte_q, byte_d;
    logic        half_q, half_d;
    logic        sext_q, sext_d;

    logic        is_byte, is_half, is_word;
    logic        misaligned, access, killed;
    logic [3:0]  sel_calc;
    logic [31:0] wdata_calc;
    logic [7:0]  lane8;
    logic [15:0] lane16;
    logic [31:0] load_fmt;

    assign is_byte    = mem_mem_byte;
    assign is_half    = ~mem_mem_byte & mem_mem_halfword;
    assign is_word    = ~mem_mem_byte & ~mem_mem_halfword;
    assign misaligned = (is_half & mem_alu_data[0]) | (is_word & (mem_alu_data[1:0] != 2'b00));
    assign access     = (mem_mem_read | mem_mem_write) & ~mem_flush & ~misaligned;

    assign exc_addr_load  = misaligned & mem_mem_read  & ~mem_flush;
    assign exc_addr_store = misaligned & mem_mem_write & ~mem_flush;
    assign mem_stall_req  = ((state_q == IDLE) & access) | (state_q == WAIT);

    // Big-endian lanes: byte offset 0 lives in bits [31:24].
    always_comb begin
        sel_calc   = 4'b1111;
        wdata_calc = mem_store_data;
        if (is_byte) begin
            sel_calc   = 4'b1000 >> mem_alu_data[1:0];
            wdata_calc = {4{mem_store_data[7:0]}};
        end else if (is_half) begin
            sel_calc   = mem_alu_data[1] ? 4'b0011 : 4'b1100;
            wdata_calc = {2{mem_store_data[15:0]}};
        end
    end

    always_comb begin
        lane8 = '0;
        case (lo_q)
            2'd0: lane8 = dmem_data_i[31:24];
            2'd1: lane8 = dmem_data_i[23:16];
            2'd2: lane8 = dmem_data_i[15:8];
            default: lane8 = dmem_data_i[7:0];
        endcase
        lane16 = lo_q[1] ? dmem_data_i[15:0] : dmem_data_i[31:16];
        if (byte_q) begin
            load_fmt = {{24{sext_q & lane8[7]}}, lane8};
        end else if (half_q) begin
            load_fmt = {{16{sext_q & lane16[15]}}, lane16};
        end else begin
            load_fmt = dmem_data_i;
        end
    end

    // A flush arriving on the ready cycle itself also suppresses the writeback.
    assign killed = abort_q | mem_flush;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        sel_d   = sel_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        berr_d  = 1'b0;
        cnt_d   = cnt_q;
        abort_d = abort_q;
        lo_d    = lo_q;
        byte_d  = byte_q;
        half_d  = half_q;
        sext_d  = sext_q;
        case (state_q)
            IDLE: begin
                if (access) begin
                    req_d   = 1'b1;
                    we_d    = mem_mem_write;
                    addr_d  = {mem_alu_data[31:2], 2'b00};
                    sel_d   = sel_calc;
                    wdata_d = wdata_calc;
                    cnt_d   = '0;
                    abort_d = 1'b0;
                    lo_d    = mem_alu_data[1:0];
                    byte_d  = is_byte;
                    half_d  = is_half;
                    sext_d  = mem_mem_sign_ext;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (mem_flush) begin
                    abort_d = 1'b1;
                end
                if (dmem_ready) begin
                    req_d = 1'b0;
                    if (!we_q && !killed) begin
                        rdata_d = load_fmt;
                    end
                    state_d = killed ? IDLE : DONE;
                end else if (cnt_q == TO_LAST) begin
                    req_d   = 1'b0;
                    berr_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            DONE: begin
                if (mem_flush || !ext_stall) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            sel_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            berr_q  <= 1'b0;
            cnt_q   <= '0;
            abort_q <= 1'b0;
            lo_q    <= '0;
            byte_q  <= 1'b0;
            half_q  <= 1'b0;
            sext_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            berr_q  <= berr_d;
            cnt_q   <= cnt_d;
            abort_q <= abort_d;
            lo_q    <= lo_d;
            byte_q  <= byte_d;
            half_q  <= half_d;
            sext_q  <= sext_d;
        end
    end

    assign dmem_request  = req_q;
    assign dmem_we       = we_q;
    assign dmem_address  = addr_q;
    assign dmem_sel      = sel_q;
    assign dmem_data_o   = wdata_q;
    assign mem_read_data = rdata_q;
    assign exc_bus_error = berr_q;

endmodule

// File: tb/tb_antares_dmem_controller.sv
// Bench for antares_dmem_controller: transaction-level expectation model compared every
// cycle, directed scenarios with literal expectations, then randomized transactions.
module tb_antares_dmem_controller;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_mem_read, mem_mem_write, mem_mem_byte, mem_mem_halfword, mem_mem_sign_ext;
    logic [31:0] mem_alu_data, mem_store_data, dmem_data_i;
    logic        mem_flush, ext_stall, dmem_ready;
    logic        dmem_request, dmem_we, mem_stall_req, exc_addr_load, exc_addr_store, exc_bus_error;
    logic [31:0] dmem_address, dmem_data_o, mem_read_data;
    logic [3:0]  dmem_sel;

    always #5 clk = ~clk;

    antares_dmem_controller #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
        .mem_mem_byte(mem_mem_byte), .mem_mem_halfword(mem_mem_halfword),
        .mem_mem_sign_ext(mem_mem_sign_ext), .mem_alu_data(mem_alu_data),
        .mem_store_data(mem_store_data), .mem_flush(mem_flush), .ext_stall(ext_stall),
        .dmem_data_i(dmem_data_i), .dmem_ready(dmem_ready),
        .dmem_request(dmem_request), .dmem_we(dmem_we), .dmem_address(dmem_address),
        .dmem_sel(dmem_sel), .dmem_data_o(dmem_data_o), .mem_read_data(mem_read_data),
        .mem_stall_req(mem_stall_req), .exc_addr_load(exc_addr_load),
        .exc_addr_store(exc_addr_store), .exc_bus_error(exc_bus_error)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;
    int stall_cnt = 0, req_cnt = 0, berr_cnt = 0;

    logic        e_req = 0, e_we = 0, e_stall = 0, e_excl = 0, e_excs = 0, e_berr = 0;
    logic [31:0] e_addr = '0, e_dout = '0, e_rdata = '0;
    logic [3:0]  e_sel = '0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check32("dmem_request",   32'(dmem_request),   32'(e_req));
            check32("dmem_we",        32'(dmem_we),        32'(e_we));
            check32("dmem_address",   dmem_address,        e_addr);
            check32("dmem_sel",       32'(dmem_sel),       32'(e_sel));
            check32("dmem_data_o",    dmem_data_o,         e_dout);
            check32("mem_read_data",  mem_read_data,       e_rdata);
            check32("mem_stall_req",  32'(mem_stall_req),  32'(e_stall));
            check32("exc_addr_load",  32'(exc_addr_load),  32'(e_excl));
            check32("exc_addr_store", 32'(exc_addr_store), 32'(e_excs));
            check32("exc_bus_error",  32'(exc_bus_error),  32'(e_berr));
            if (mem_stall_req) stall_cnt++;
            if (dmem_request)  req_cnt++;
            if (exc_bus_error) berr_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        e_berr = 1'b0;
    endtask

    function automatic logic [3:0] f_sel(input int unsigned off, input int unsigned n);
        logic [3:0] s = '0;
        for (int unsigned j = 0; j < n; j++) s[3 - (off + j)] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] f_store(input logic [31:0] d, input int unsigned n);
        if (n == 1) return {24'b0, d[7:0]} * 32'h01010101;
        if (n == 2) return {16'b0, d[15:0]} * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] f_load(input logic [31:0] d, input int unsigned off,
                                           input int unsigned n, input bit sx);
        logic [31:0] v;
        logic [31:0] mask;
        int unsigned bits;
        bits = 8 * n;
        v = d >> (8 * (4 - off - n));
        if (n < 4) begin
            mask = (32'd1 << bits) - 32'd1;
            v = v & mask;
            if (sx && v[bits - 1]) v = v | ~mask;
        end
        return v;
    endfunction

    task automatic idle_cycle();
        mem_mem_read = 0; mem_mem_write = 0;
        mem_flush = 1'($urandom_range(0, 1)); dmem_ready = 1'($urandom_range(0, 1));
        ext_stall = 1'($urandom_range(0, 1));
        mem_alu_data = $urandom; mem_store_data = $urandom; dmem_data_i = $urandom;
        e_stall = 0; e_excl = 0; e_excs = 0;
        step();
    endtask

    // flush_at: -1 none, 0 in the issue cycle, i>=1 in wait cycle i; rdy_at 0 = never.
    task automatic xact(input bit rd, input bit wr, input bit byt, input bit half, input bit sx,
                        input logic [31:0] addr, input logic [31:0] sdata, input logic [31:0] rdata,
                        input int rdy_at, input int flush_at, input int dstall, input bit dflush);
        int unsigned n, off;
        bit mis, acc, aborted, leave;
        n   = byt ? 1 : (half ? 2 : 4);
        off = 32'(addr[1:0]);
        mis = (off % n) != 0;
        acc = (rd || wr) && !mis && (flush_at != 0);
        mem_mem_read = rd; mem_mem_write = wr; mem_mem_byte = byt; mem_mem_halfword = half;
        mem_mem_sign_ext = sx; mem_alu_data = addr; mem_store_data = sdata;
        mem_flush = (flush_at == 0); dmem_ready = 1'($urandom_range(0, 1));
        ext_stall = 1'($urandom_range(0, 1)); dmem_data_i = $urandom;
        e_stall = acc;
        e_excl = mis && rd && (flush_at != 0);
        e_excs = mis && wr && (flush_at != 0);
        step();
        if (!acc) return;
        e_req = 1; e_we = wr; e_addr = {addr[31:2], 2'b00};
        e_sel = f_sel(off, n); e_dout = f_store(sdata, n);
        e_stall = 1; e_excl = 0; e_excs = 0;
        aborted = 0;
        for (int i = 1; i <= int'(TO); i++) begin
            dmem_ready = (i == rdy_at);
            mem_flush = (i == flush_at);
            if (mem_flush) aborted = 1;
            dmem_data_i = dmem_ready ? rdata : $urandom;
            ext_stall = 1'($urandom_range(0, 1));
            step();
            if (i == rdy_at) begin
                e_req = 0;
                if (!wr && !aborted) e_rdata = f_load(rdata, off, n, sx);
                break;
            end
            if (i == int'(TO)) begin
                e_req = 0; e_berr = 1; aborted = 1;
            end
        end
        if (aborted) return;
        e_stall = 0;
        for (int d = 0; d <= dstall; d++) begin
            ext_stall = (d < dstall);
            mem_flush = dflush && (d == 0);
            dmem_ready = 1'($urandom_range(0, 1)); dmem_data_i = $urandom;
            leave = mem_flush || !ext_stall;
            step();
            if (leave) break;
        end
    endtask

    task automatic reset_mid_wait(input int waits);
        mem_mem_read = 1; mem_mem_write = 0; mem_mem_byte = 0; mem_mem_halfword = 0;
        mem_mem_sign_ext = 0; mem_alu_data = 32'h0000_0400; mem_flush = 0; dmem_ready = 0;
        e_stall = 1; e_excl = 0; e_excs = 0;
        step();
        e_req = 1; e_we = 0; e_addr = 32'h0000_0400; e_sel = 4'hF; e_dout = mem_store_data;
        for (int k = 0; k < waits; k++) step();
        rst = 1;
        step();
        rst = 0;
        e_req = 0; e_we = 0; e_addr = '0; e_sel = '0; e_dout = '0; e_rdata = '0;
        mem_mem_read = 0; e_stall = 0;
        #1;
        check32("rst_mid request", 32'(dmem_request), 32'h0);
        check32("rst_mid read_data", mem_read_data, 32'h0);
        check32("rst_mid bus_error", 32'(exc_bus_error), 32'h0);
        idle_cycle();
        check32("rst_mid no berr later", 32'(exc_bus_error), 32'h0);
    endtask

    initial begin
        rst = 1; mem_mem_read = 0; mem_mem_write = 0; mem_mem_byte = 0; mem_mem_halfword = 0;
        mem_mem_sign_ext = 0; mem_alu_data = '0; mem_store_data = '0; mem_flush = 0;
        ext_stall = 0; dmem_data_i = '0; dmem_ready = 0;
        step();
        chk_en = 1'b1;
        step();
        rst = 0;
        check32("reset request", 32'(dmem_request), 32'h0);
        check32("reset read_data", mem_read_data, 32'h0);

        // lw 0x100, ready on third wait cycle
        stall_cnt = 0;
        xact(1, 0, 0, 0, 0, 32'h100, 32'h0, 32'hDEADBEEF, 3, -1, 0, 0);
        check32("t1 read_data", mem_read_data, 32'hDEADBEEF);
        check32("t1 sel", 32'(dmem_sel), 32'hF);
        check32("t1 stall cycles", 32'(stall_cnt), 32'd4);

        xact(1, 0, 1, 0, 1, 32'h103, 32'h0, 32'h000000F0, 1, -1, 0, 0);
        check32("t2 lb", mem_read_data, 32'hFFFFFFF0);
        check32("t2 sel", 32'(dmem_sel), 32'h1);
        xact(1, 0, 1, 0, 0, 32'h103, 32'h0, 32'h000000F0, 2, -1, 1, 0);
        check32("t2 lbu", mem_read_data, 32'h000000F0);

        xact(0, 1, 0, 1, 0, 32'h202, 32'h1234ABCD, 32'h0, 1, -1, 0, 0);
        check32("t3 we", 32'(dmem_we), 32'h1);
        check32("t3 sel", 32'(dmem_sel), 32'h3);
        check32("t3 data_o", dmem_data_o, 32'hABCDABCD);
        check32("t3 address", dmem_address, 32'h200);

        mem_mem_read = 1; mem_mem_write = 0; mem_mem_byte = 0; mem_mem_halfword = 0;
        mem_alu_data = 32'h101; mem_flush = 0;
        e_stall = 0; e_excl = 1; e_excs = 0;
        #2;
        check32("t4 exc_addr_load", 32'(exc_addr_load), 32'h1);
        check32("t4 stall", 32'(mem_stall_req), 32'h0);
        step();
        check32("t4 request", 32'(dmem_request), 32'h0);
        idle_cycle();

        req_cnt = 0; berr_cnt = 0;
        xact(1, 0, 0, 0, 0, 32'h300, 32'h0, 32'h0, 0, -1, 0, 0);
        idle_cycle(); idle_cycle();
        check32("t5 request cycles", 32'(req_cnt), 32'd4);
        check32("t5 berr pulses", 32'(berr_cnt), 32'd1);

        stall_cnt = 0;
        xact(1, 0, 0, 0, 0, 32'h400, 32'h0, 32'h11223344, 3, 1, 0, 0);
        check32("t6 stall cycles", 32'(stall_cnt), 32'd4);
        check32("t6 read_data kept", mem_read_data, 32'h000000F0);
        idle_cycle();

        reset_mid_wait(2);

        for (int t = 0; t < 300; t++) begin
            bit rd, wr;
            int r, fa, ra;
            r  = $urandom_range(0, 9);
            rd = (r < 5); wr = (r >= 5 && r < 9);
            ra = $urandom_range(0, TO + 1);
            if (ra > int'(TO)) ra = 0;
            r  = $urandom_range(0, 9);
            fa = (r == 0) ? 0 : ((r == 1) ? $urandom_range(1, TO) : -1);
            xact(rd, wr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                 ra, fa, $urandom_range(0, 3), ($urandom_range(0, 4) == 0));
            if ($urandom_range(0, 2) == 0) idle_cycle();
        end
        idle_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
